// File: rtl/register_file_scoreboard.sv
// Architectural register file fed by write-back, with two bypassed decode read
// ports and a per-register pending scoreboard that stalls decode on RAW/WAW hazards.
module register_file_scoreboard #(
  parameter int DATA_W = 22,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              issue_valid,
  input  logic              issue_uses_a,
  input  logic              issue_uses_b,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              stall,
  output logic [NREGS-1:0]  pending,
  output logic [ADDR_W:0]   inflight_cnt,
  output logic              wb_orphan
);

  function automatic logic [ADDR_W:0] popcount(input logic [NREGS-1:0] vec);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  clr_vec_s;
  logic [NREGS-1:0]  set_vec_s;
  logic [NREGS-1:0]  busy_vec_s;
  logic [NREGS-1:0]  pending_nxt_s;
  logic              issue_fire_s;

  // Hazard detection: a producer completing this cycle no longer blocks decode
  always_comb begin
    clr_vec_s = '0;
    if (wb_we) begin
      clr_vec_s[wb_addr] = 1'b1;
    end else begin
      clr_vec_s = '0;
    end
    busy_vec_s = pending & ~clr_vec_s;

    stall = 1'b0;
    if (rst && issue_valid) begin
      stall = (issue_uses_a && busy_vec_s[rd_addr_a]) ||
              (issue_uses_b && busy_vec_s[rd_addr_b]) ||
              (issue_wr     && busy_vec_s[issue_dest]);
    end else begin
      stall = 1'b0;
    end
    issue_fire_s = rst && issue_valid && !stall;

    set_vec_s = '0;
    if (issue_fire_s && issue_wr) begin
      set_vec_s[issue_dest] = 1'b1;
    end else begin
      set_vec_s = '0;
    end
    // A new producer on the completing register keeps the bit set
    pending_nxt_s = (pending & ~clr_vec_s) | set_vec_s;
  end

  // Read ports with same-cycle write-back bypass, forced to zero in reset
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (!rst) begin
      rd_data_a = '0;
      rd_data_b = '0;
    end else begin
      if (wb_we && (wb_addr == rd_addr_a)) begin
        rd_data_a = wb_data;
      end else begin
        rd_data_a = regs_r[rd_addr_a];
      end
      if (wb_we && (wb_addr == rd_addr_b)) begin
        rd_data_b = wb_data;
      end else begin
        rd_data_b = regs_r[rd_addr_b];
      end
    end
  end

  // Register array, scoreboard, in-flight count and sticky orphan flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
      pending      <= '0;
      inflight_cnt <= '0;
      wb_orphan    <= 1'b0;
    end else begin
      if (wb_we) begin
        regs_r[wb_addr] <= wb_data;
      end
      if (wb_we && !pending[wb_addr]) begin
        wb_orphan <= 1'b1;
      end
      pending      <= pending_nxt_s;
      inflight_cnt <= popcount(pending_nxt_s);
    end
  end

endmodule
